// File: rtl/periph_rx_arbiter_if.sv
// RX arbiter bundle: per-peripheral FIFO status in, grant/read strobes out.
// The master modport is the arbiter; the slave modport is the FIFO/mux side.
interface periph_rx_arbiter_if #(
  parameter int NUM_PERIPHS = 8
);
  localparam int GRANT_W = $clog2(NUM_PERIPHS);

  logic [NUM_PERIPHS-1:0] rx_fifo_empty;
  logic [NUM_PERIPHS-1:0] rx_fifo_almost_full;
  logic                   out_fifo_full;
  logic [GRANT_W-1:0]     grant;
  logic                   grant_valid;
  logic [NUM_PERIPHS-1:0] rx_read;

  modport master (
    input  rx_fifo_empty, rx_fifo_almost_full, out_fifo_full,
    output grant, grant_valid, rx_read
  );

  modport slave (
    output rx_fifo_empty, rx_fifo_almost_full, out_fifo_full,
    input  grant, grant_valid, rx_read
  );
endinterface

// File: rtl/periph_rx_arbiter.sv
// Burst round-robin arbiter draining peripheral RX FIFOs into the shared output FIFO.
// Optional starvation guard: define PERIPH_RX_ARB_STARVE_GUARD_EN.
//
// state | meaning
// IDLE  | no owner; pick next winner (urgent first, then normal), grant_valid=0
// HOLD  | owner drains words until burst limit, empty, or urgent preemption
module periph_rx_arbiter #(
  parameter int NUM_PERIPHS  = 8,
  parameter int MAX_BURST    = 16,
  parameter int STARVE_LIMIT = 256
) (
  input  logic                clk,
  input  logic                rst,
  periph_rx_arbiter_if.master bus
);
  localparam int GRANT_W = $clog2(NUM_PERIPHS);
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  if (NUM_PERIPHS < 2 || (NUM_PERIPHS & (NUM_PERIPHS - 1)) != 0 ||
      MAX_BURST < 1 || STARVE_LIMIT < 1) begin : g_bad_params
    $error("periph_rx_arbiter: illegal parameter set");
  end

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [GRANT_W-1:0]     grant_q, grant_d;
  logic [GRANT_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [GRANT_W-1:0]     winner;
  logic [BURST_W-1:0]     burst_cnt_q, burst_cnt_d;
  logic [NUM_PERIPHS-1:0] req, urg, starved, sel_urg, sel_vec, grant_oh;
  logic                   xfer, owner_empty, last_word, other_urgent, preempt, hold_locked;

  function automatic logic [GRANT_W-1:0] rr_pick(input logic [NUM_PERIPHS-1:0] vec,
                                                 input logic [GRANT_W-1:0]     ptr);
    logic [GRANT_W-1:0] idx;
    logic               found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 1; i <= NUM_PERIPHS; i++) begin
      idx = ptr + GRANT_W'(i);
      if (!found && vec[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign req      = ~bus.rx_fifo_empty;
  assign urg      = req & bus.rx_fifo_almost_full;
  assign sel_urg  = urg | starved;
  assign sel_vec  = (|sel_urg) ? sel_urg : req;
  assign winner   = rr_pick(sel_vec, rr_ptr_q);
  assign grant_oh = NUM_PERIPHS'(1) << grant_q;

  assign owner_empty  = bus.rx_fifo_empty[grant_q];
  assign xfer         = (state_q == HOLD) && !owner_empty && !bus.out_fifo_full;
  assign last_word    = xfer && (burst_cnt_q == BURST_W'(MAX_BURST - 1));
  assign other_urgent = |(urg & ~grant_oh);
  // An owner stalled by backpressure keeps the grant; preempt only on a transfer or when drained.
  assign preempt      = !hold_locked && !urg[grant_q] && other_urgent && (xfer || owner_empty);

`ifdef PERIPH_RX_ARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  logic [WAIT_W-1:0] wait_cnt [NUM_PERIPHS];
  logic              owner_starved_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PERIPHS; i++) wait_cnt[i] <= '0;
      owner_starved_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PERIPHS; i++) begin
        if (!req[i] || (state_q == HOLD && grant_q == GRANT_W'(i)))
          wait_cnt[i] <= '0;
        else if (wait_cnt[i] != WAIT_W'(STARVE_LIMIT))
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
      if (state_q == IDLE && |req)
        owner_starved_q <= starved[winner];
    end
  end

  always_comb begin
    starved = '0;
    for (int i = 0; i < NUM_PERIPHS; i++)
      starved[i] = req[i] && (wait_cnt[i] == WAIT_W'(STARVE_LIMIT));
  end

  assign hold_locked = owner_starved_q;
`else
  assign starved     = '0;
  assign hold_locked = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d     = winner;
          rr_ptr_d    = winner;
          burst_cnt_d = '0;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (xfer) burst_cnt_d = burst_cnt_q + 1'b1;
        if (last_word || owner_empty || preempt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= GRANT_W'(NUM_PERIPHS - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = xfer;
  assign bus.rx_read     = xfer ? grant_oh : '0;
endmodule
